// File: rtl/int_divide_seq.sv
// Sequential signed integer divider: restoring division on operand magnitudes,
// one quotient bit per cycle, with valid/ready handshakes on both sides.
module int_divide_seq #(
    parameter int DIVIDEND_WIDTH = 16,
    parameter int DIVISOR_WIDTH  = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [DIVIDEND_WIDTH-1:0] data_in_dividend,
    input  logic [DIVISOR_WIDTH-1:0]  data_in_divisor,
    input  logic                      data_in_valid,
    output logic                      data_in_ready,
    output logic [DIVIDEND_WIDTH-1:0] data_out_quotient,
    output logic [DIVISOR_WIDTH-1:0]  data_out_remainder,
    output logic                      data_out_div_by_zero,
    output logic                      data_out_overflow,
    output logic                      data_out_valid,
    input  logic                      data_out_ready
);

    localparam int DW = DIVIDEND_WIDTH;
    localparam int SW = DIVISOR_WIDTH;
    localparam int CW = $clog2(DW + 1);

    localparam logic [DW-1:0] ONE_DW   = {{(DW-1){1'b0}}, 1'b1};
    localparam logic [SW-1:0] ONE_SW   = {{(SW-1){1'b0}}, 1'b1};
    localparam logic [DW-1:0] MIN_DW   = {1'b1, {(DW-1){1'b0}}};
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_LAST = CW'(DW - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_r, state_s;
    logic [DW-1:0]   dvd_r, dvd_s;       // dividend magnitude, shifts into quotient magnitude
    logic [SW-1:0]   dvs_r, dvs_s;
    logic [SW:0]     prem_r, prem_s;
    logic [CW-1:0]   cnt_r, cnt_s;
    logic            qsign_r, qsign_s;
    logic            rsign_r, rsign_s;
    logic            dz_r, dz_s;
    logic [DW-1:0]   quot_r, quot_s;
    logic [SW-1:0]   rem_r, rem_s;
    logic            dzout_r, dzout_s;
    logic            ovf_r, ovf_s;
    logic            valid_r, valid_s;
    logic            ready_r, ready_s;

    logic [SW+1:0]   trial_s;
    logic [SW+1:0]   diff_s;
    logic            qbit_s;
    logic [DW-1:0]   qmag_s;
    logic [SW:0]     prem_new_s;

    function automatic logic [DW-1:0] mag_dw(input logic [DW-1:0] v);
        return v[DW-1] ? (~v + ONE_DW) : v;
    endfunction

    function automatic logic [SW-1:0] mag_sw(input logic [SW-1:0] v);
        return v[SW-1] ? (~v + ONE_SW) : v;
    endfunction

    // One restoring-division step on the current partial remainder.
    always_comb begin
        trial_s    = {prem_r, dvd_r[DW-1]};
        diff_s     = trial_s - {2'b00, dvs_r};
        qbit_s     = (trial_s >= {2'b00, dvs_r});
        qmag_s     = {dvd_r[DW-2:0], qbit_s};
        prem_new_s = qbit_s ? diff_s[SW:0] : trial_s[SW:0];
    end

    // Next-state, datapath and output-register logic.
    always_comb begin
        state_s = state_r;
        dvd_s   = dvd_r;
        dvs_s   = dvs_r;
        prem_s  = prem_r;
        cnt_s   = cnt_r;
        qsign_s = qsign_r;
        rsign_s = rsign_r;
        dz_s    = dz_r;
        quot_s  = quot_r;
        rem_s   = rem_r;
        dzout_s = dzout_r;
        ovf_s   = ovf_r;
        case (state_r)
            IDLE: begin
                if (data_in_valid) begin
                    dvd_s   = mag_dw(data_in_dividend);
                    dvs_s   = mag_sw(data_in_divisor);
                    qsign_s = data_in_dividend[DW-1] ^ data_in_divisor[SW-1];
                    rsign_s = data_in_dividend[DW-1];
                    dz_s    = (data_in_divisor == {SW{1'b0}});
                    prem_s  = {(SW+1){1'b0}};
                    cnt_s   = {CW{1'b0}};
                    dzout_s = 1'b0;
                    ovf_s   = 1'b0;
                    state_s = CALC;
                end else begin
                    state_s = IDLE;
                end
            end
            CALC: begin
                dvd_s  = qmag_s;
                prem_s = prem_new_s;
                if (cnt_r == CNT_LAST) begin
                    cnt_s   = {CW{1'b0}};
                    state_s = DONE;
                    // Sign fix on the final step's results.
                    if (dz_r) begin
                        quot_s  = {DW{1'b1}};
                        rem_s   = {SW{1'b0}};
                        dzout_s = 1'b1;
                        ovf_s   = 1'b0;
                    end else if ((qmag_s == MIN_DW) && !qsign_r) begin
                        quot_s  = MIN_DW;
                        rem_s   = {SW{1'b0}};
                        dzout_s = 1'b0;
                        ovf_s   = 1'b1;
                    end else begin
                        quot_s  = qsign_r ? (~qmag_s + ONE_DW) : qmag_s;
                        rem_s   = rsign_r ? (~prem_new_s[SW-1:0] + ONE_SW) : prem_new_s[SW-1:0];
                        dzout_s = 1'b0;
                        ovf_s   = 1'b0;
                    end
                end else begin
                    cnt_s   = cnt_r + CNT_ONE;
                    state_s = CALC;
                end
            end
            DONE: begin
                if (data_out_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
        ready_s = (state_s == IDLE);
        valid_s = (state_s == DONE);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            dvd_r   <= {DW{1'b0}};
            dvs_r   <= {SW{1'b0}};
            prem_r  <= {(SW+1){1'b0}};
            cnt_r   <= {CW{1'b0}};
            qsign_r <= 1'b0;
            rsign_r <= 1'b0;
            dz_r    <= 1'b0;
            quot_r  <= {DW{1'b0}};
            rem_r   <= {SW{1'b0}};
            dzout_r <= 1'b0;
            ovf_r   <= 1'b0;
            valid_r <= 1'b0;
            ready_r <= 1'b1;
        end else begin
            state_r <= state_s;
            dvd_r   <= dvd_s;
            dvs_r   <= dvs_s;
            prem_r  <= prem_s;
            cnt_r   <= cnt_s;
            qsign_r <= qsign_s;
            rsign_r <= rsign_s;
            dz_r    <= dz_s;
            quot_r  <= quot_s;
            rem_r   <= rem_s;
            dzout_r <= dzout_s;
            ovf_r   <= ovf_s;
            valid_r <= valid_s;
            ready_r <= ready_s;
        end
    end

    assign data_in_ready        = ready_r;
    assign data_out_valid       = valid_r;
    assign data_out_quotient    = quot_r;
    assign data_out_remainder   = rem_r;
    assign data_out_div_by_zero = dzout_r;
    assign data_out_overflow    = ovf_r;

endmodule

// File: tb/tb_int_divide_seq.sv
// Directed self-checking bench for int_divide_seq (16-bit dividend, 8-bit divisor).
module tb_int_divide_seq;

    logic        clk;
    logic        rst_n;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        div_by_zero;
    logic        overflow;
    logic        out_valid;
    logic        out_ready;

    int n_checks = 0;
    int n_pass   = 0;

    int_divide_seq #(
        .DIVIDEND_WIDTH(16),
        .DIVISOR_WIDTH (8)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .data_in_dividend    (dividend),
        .data_in_divisor     (divisor),
        .data_in_valid       (in_valid),
        .data_in_ready       (in_ready),
        .data_out_quotient   (quotient),
        .data_out_remainder  (remainder),
        .data_out_div_by_zero(div_by_zero),
        .data_out_overflow   (overflow),
        .data_out_valid      (out_valid),
        .data_out_ready      (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present operands, wait for the result and check latency and values (no handshake).
    task automatic run_div(input string tag, input logic [15:0] a, input logic [7:0] b,
                           input logic [15:0] eq, input logic [7:0] er,
                           input logic edz, input logic eovf);
        int lat;
        @(negedge clk);
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        check_eq({tag, ":in_ready_idle"}, {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check_eq({tag, ":in_ready_busy"}, {31'd0, in_ready}, 32'd0);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_eq({tag, ":latency"}, lat, 32'd16);
        check_eq({tag, ":q"}, {16'd0, quotient}, {16'd0, eq});
        check_eq({tag, ":r"}, {24'd0, remainder}, {24'd0, er});
        check_eq({tag, ":dz"}, {31'd0, div_by_zero}, {31'd0, edz});
        check_eq({tag, ":ovf"}, {31'd0, overflow}, {31'd0, eovf});
    endtask

    // Handshake edge with data_out_ready=1: valid drops, input side reopens.
    task automatic drain(input string tag);
        @(posedge clk);
        #1;
        check_eq({tag, ":valid_drop"}, {31'd0, out_valid}, 32'd0);
        check_eq({tag, ":ready_back"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        rst_n     = 1'b0;
        dividend  = 16'd0;
        divisor   = 8'd0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #12;
        check_eq("rst:in_ready", {31'd0, in_ready}, 32'd1);
        check_eq("rst:valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst:q", {16'd0, quotient}, 32'd0);
        check_eq("rst:r", {24'd0, remainder}, 32'd0);
        check_eq("rst:flags", {30'd0, div_by_zero, overflow}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_div("p100_p7", 16'd100, 8'd7, 16'd14, 8'd2, 1'b0, 1'b0);            drain("p100_p7");
        run_div("m100_p7", 16'hFF9C, 8'd7, 16'hFFF2, 8'hFE, 1'b0, 1'b0);        drain("m100_p7");
        run_div("p100_m7", 16'd100, 8'hF9, 16'hFFF2, 8'h02, 1'b0, 1'b0);        drain("p100_m7");
        run_div("m100_m7", 16'hFF9C, 8'hF9, 16'h000E, 8'hFE, 1'b0, 1'b0);       drain("m100_m7");
        run_div("min_m1", 16'h8000, 8'hFF, 16'h8000, 8'h00, 1'b0, 1'b1);        drain("min_m1");
        run_div("min_p1", 16'h8000, 8'h01, 16'h8000, 8'h00, 1'b0, 1'b0);        drain("min_p1");
        run_div("p127_m128", 16'h007F, 8'h80, 16'h0000, 8'h7F, 1'b0, 1'b0);    drain("p127_m128");
        run_div("p5_z", 16'd5, 8'd0, 16'hFFFF, 8'h00, 1'b1, 1'b0);              drain("p5_z");
        run_div("m5_z", 16'hFFFB, 8'd0, 16'hFFFF, 8'h00, 1'b1, 1'b0);           drain("m5_z");

        // Backpressure: result must hold while new operands are offered and ignored.
        @(negedge clk);
        out_ready = 1'b0;
        run_div("bp", 16'd1000, 8'd3, 16'd333, 8'd1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            dividend = 16'd5;
            divisor  = 8'd1;
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            check_eq("bp:q_hold", {16'd0, quotient}, 32'd333);
            check_eq("bp:r_hold", {24'd0, remainder}, 32'd1);
            check_eq("bp:valid_hold", {31'd0, out_valid}, 32'd1);
            check_eq("bp:in_ready_low", {31'd0, in_ready}, 32'd0);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain("bp");
        @(posedge clk);
        #1;
        check_eq("bp:no_accept", {31'd0, in_ready}, 32'd1);

        // Asynchronous reset in the middle of the iterations.
        @(negedge clk);
        dividend = 16'd500;
        divisor  = 8'd7;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("mrst:q", {16'd0, quotient}, 32'd0);
        check_eq("mrst:r", {24'd0, remainder}, 32'd0);
        check_eq("mrst:valid", {31'd0, out_valid}, 32'd0);
        check_eq("mrst:in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            check_eq("mrst:no_stale", {31'd0, out_valid}, 32'd0);
        end
        run_div("p9_p2", 16'd9, 8'd2, 16'd4, 8'd1, 1'b0, 1'b0);
        drain("p9_p2");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/int_divide_seq.md
Name: int_divide_seq

Overview:
- Sequential signed integer divider; the inverse of the team's combinational signed multiplier.
- Computes quotient and remainder of two signed fixed-point integers using iterative restoring division on magnitudes, one quotient bit per cycle.
- Sits in datapaths that need rescaling or normalisation and cannot afford a combinational divider.
- Uses valid/ready handshakes on both input and output.

Parameters:
- DIVIDEND_WIDTH, 16, bit width of signed dividend and quotient (≥2).
- DIVISOR_WIDTH, 8, bit width of signed divisor and remainder (≥2).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- data_in_dividend  input  DIVIDEND_WIDTH  signed dividend.
- data_in_divisor  input  DIVISOR_WIDTH  signed divisor.
- data_in_valid  input  1  operands valid.
- data_in_ready  output  1  divider can accept operands.
- data_out_quotient  output  DIVIDEND_WIDTH  signed quotient.
- data_out_remainder  output  DIVISOR_WIDTH  signed remainder.
- data_out_div_by_zero  output  1  divisor was zero.
- data_out_overflow  output  1  quotient magnitude did not fit (min / -1).
- data_out_valid  output  1  results valid.
- data_out_ready  input  1  downstream accepts results.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (rst_n). While rst_n=0:
  - State = IDLE, data_in_ready=1, data_out_valid=0.
  - Quotient, remainder and both flags = 0.
  - Iteration counter = 0.
- Reset asserted mid-operation aborts the division; no result is produced.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - data_in_ready=1.
  - On an edge with data_in_valid=1, operands are captured. The block records:
    - |dividend| as unsigned DIVIDEND_WIDTH bits;
    - |divisor| as unsigned DIVISOR_WIDTH bits;
    - quotient sign = sign(dividend) XOR sign(divisor);
    - remainder sign = sign(dividend);
    - zero-divisor flag.
  - The partial remainder register (DIVISOR_WIDTH+1 bits) is cleared, counter = 0, state goes to CALC.
  - The most-negative operand value has magnitude 2^(W-1); this must be representable unsigned.
- CALC (one quotient bit per edge, MSB first, data_in_ready=0):
  - trial = {partial_remainder, next dividend magnitude bit}.
  - If trial ≥ |divisor|: partial_remainder = trial − |divisor|, quotient bit = 1. Otherwise partial_remainder = trial, quotient bit = 0.
  - After DIVIDEND_WIDTH iterations, state goes to DONE.
- Latency:
  - data_out_valid rises exactly DIVIDEND_WIDTH rising edges after the accepting edge.
  - Latency is fixed regardless of operand values, including divide-by-zero.
- Sign fix, applied when entering DONE:
  - Quotient is negated (two's complement, DIVIDEND_WIDTH bits) if quotient sign = 1.
  - Remainder is negated if dividend was negative.
  - Result: truncation toward zero; remainder takes the dividend's sign; dividend = quotient × divisor + remainder.
  - The remainder magnitude is always < |divisor|, so it always fits DIVISOR_WIDTH signed.
- Overflow: if the quotient magnitude equals 2^(DIVIDEND_WIDTH-1) and the quotient is positive, then:
  - quotient = most-negative value (wraps);
  - remainder = 0;
  - data_out_overflow = 1.
- Divide by zero:
  - quotient = all ones (−1), remainder = 0, data_out_div_by_zero = 1, data_out_overflow = 0.
- DONE:
  - data_out_valid=1. All outputs are held stable until data_out_valid & data_out_ready.
  - On that handshake edge: state goes to IDLE, data_out_valid → 0.
  - data_in_ready returns to 1 in the following cycle.
  - There is no same-cycle output/input bypass; the sustained throughput is one result per DIVIDEND_WIDTH+2 cycles.
- data_in_valid while busy is ignored; operands are not latched. Upstream must hold them until data_in_ready.
- Flags are cleared on each new accept.
- Outputs are registered; no combinational path from inputs to outputs. data_in_ready depends only on state.

Test Plan (all with DIVIDEND_WIDTH=16, DIVISOR_WIDTH=8, data_out_ready=1 unless stated):
- 100 / 7 → q=14, r=2, both flags 0. data_out_valid first high 16 edges after accept.
- −100 / 7 → q=−14, r=−2. 100 / −7 → q=−14, r=2. −100 / −7 → q=14, r=−2.
- −32768 / −1 → q=−32768 (0x8000), r=0, overflow=1. −32768 / 1 → q=−32768, overflow=0. 127 / −128 → q=0, r=127.
- 5 / 0 and −5 / 0 → q=0xFFFF, r=0, div_by_zero=1, latency still 16.
- Backpressure: 1000 / 3 with data_out_ready=0 for 10 cycles after valid. Required:
  - q=333, r=1 held stable with data_out_valid=1;
  - data_in_ready stays 0 and a new data_in_valid is ignored;
  - after ready, data_in_ready=1 the next cycle.
- Reset mid-CALC: pull rst_n low asynchronously on iteration 8.
  - Outputs go to 0 and data_in_ready=1 immediately.
  - After release, 9 / 2 yields q=4, r=1 with no stale result emitted.
